dual_issue_scheduler: RTL and testbench

//  Issue controller for the two-slot ID/EX pipeline register. Each cycle, decides whether the decoded

---
 rtl/dual_issue_scheduler.sv | 123 ++++++++++++
 tb/tb_dual_issue_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Issue controller for the two-slot ID/EX register: dual issue, split issue or stall,
// with per-slot kill (bubble) and saturating stall/split performance counters.
module dual_issue_scheduler #(
   parameter int CNT_W      = 16,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  id_valid_1,
   input  logic                  id_valid_2,
   input  logic [REG_ADDR_W-1:0] id_rs1_1,
   input  logic [REG_ADDR_W-1:0] id_rs1_2,
   input  logic [REG_ADDR_W-1:0] id_rs2_1,
   input  logic [REG_ADDR_W-1:0] id_rs2_2,
   input  logic [REG_ADDR_W-1:0] id_rd_1,
   input  logic [REG_ADDR_W-1:0] id_rd_2,
   input  logic                  id_regwrite_1,
   input  logic                  id_regwrite_2,
   input  logic                  id_mem_1,
   input  logic                  id_mem_2,
   input  logic                  ex_memread_1,
   input  logic                  ex_memread_2,
   input  logic [REG_ADDR_W-1:0] ex_rd_1,
   input  logic [REG_ADDR_W-1:0] ex_rd_2,
   output logic                  stall,
   output logic                  kill_1,
   output logic                  kill_2,
   output logic                  split_pending,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      split_cnt
);

   typedef enum logic {
      PAIR  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   state_t state, state_next;
   logic   lu_1, lu_2, ip;
   logic   stall_inc, split_inc;

   // True when a non-x0 destination matches either source operand.
   function automatic logic reads_reg(input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] rs1,
                                      input logic [REG_ADDR_W-1:0] rs2);
      return (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

   // rs2 is always compared, so I-type consumers stall conservatively.
   assign lu_1 = id_valid_1 &&
                 ((ex_memread_1 && reads_reg(ex_rd_1, id_rs1_1, id_rs2_1)) ||
                  (ex_memread_2 && reads_reg(ex_rd_2, id_rs1_1, id_rs2_1)));
   assign lu_2 = id_valid_2 &&
                 ((ex_memread_1 && reads_reg(ex_rd_1, id_rs1_2, id_rs2_2)) ||
                  (ex_memread_2 && reads_reg(ex_rd_2, id_rs1_2, id_rs2_2)));

   assign ip = id_valid_1 && id_valid_2 &&
               ((id_regwrite_1 && reads_reg(id_rd_1, id_rs1_2, id_rs2_2)) ||
                (id_mem_1 && id_mem_2) ||
                (id_regwrite_1 && id_regwrite_2 && (id_rd_1 == id_rd_2) && (id_rd_1 != '0)));

   assign split_pending = (state == SPLIT);

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      stall      = 1'b0;
      kill_1     = 1'b1;
      kill_2     = 1'b1;
      state_next = state;
      stall_inc  = 1'b0;
      split_inc  = 1'b0;
      if (!reset) begin
         state_next = PAIR;
      end else if (flush) begin
         state_next = PAIR;
      end else begin
         unique case (state)
            PAIR: begin
               if (lu_1 || lu_2) begin
                  stall     = 1'b1;
                  stall_inc = 1'b1;
               end else if (ip) begin
                  stall      = 1'b1;
                  kill_1     = 1'b0;
                  state_next = SPLIT;
                  split_inc  = 1'b1;
               end else begin
                  kill_1 = ~id_valid_1;
                  kill_2 = ~id_valid_2;
               end
            end
            SPLIT: begin
               // Slot1 already sits in ID/EX; only slot2 can still be blocked by a load.
               if (lu_2) begin
                  stall     = 1'b1;
                  stall_inc = 1'b1;
               end else begin
                  kill_2     = 1'b0;
                  state_next = PAIR;
               end
            end
            default: state_next = PAIR;
         endcase
      end
   end

   // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= PAIR;
         stall_cnt <= '0;
         split_cnt <= '0;
      end else begin
         state <= state_next;
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (split_inc && (split_cnt != '1))
            split_cnt <= split_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios plus random stimulus,
// compared against a behavioural model of the issue rules; a 2-bit-counter copy checks saturation.
module tb_dual_issue_scheduler;

   localparam int RW = 5;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          valid    [1:2];
   logic [RW-1:0] rs1      [1:2];
   logic [RW-1:0] rs2      [1:2];
   logic [RW-1:0] rd       [1:2];
   logic          regwrite [1:2];
   logic          mem      [1:2];
   logic          ex_mr    [1:2];
   logic [RW-1:0] ex_rd    [1:2];

   logic        stall, kill_1, kill_2, split_pending;
   logic [15:0] stall_cnt, split_cnt;
   logic        s_stall, s_kill_1, s_kill_2, s_split_pending;
   logic [1:0]  s_stall_cnt, s_split_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: pending slot2 flag and plain integer counters.
   bit m_split;
   int m_stall_cnt, m_split_cnt, m_stall_cnt_small;
   bit e_stall, e_kill_1, e_kill_2, e_next_split, e_stall_inc, e_split_inc;

   dual_issue_scheduler #(.CNT_W(16), .REG_ADDR_W(RW)) dut (
      .clk(clk), .reset(rst), .flush(flush),
      .id_valid_1(valid[1]), .id_valid_2(valid[2]),
      .id_rs1_1(rs1[1]), .id_rs1_2(rs1[2]),
      .id_rs2_1(rs2[1]), .id_rs2_2(rs2[2]),
      .id_rd_1(rd[1]), .id_rd_2(rd[2]),
      .id_regwrite_1(regwrite[1]), .id_regwrite_2(regwrite[2]),
      .id_mem_1(mem[1]), .id_mem_2(mem[2]),
      .ex_memread_1(ex_mr[1]), .ex_memread_2(ex_mr[2]),
      .ex_rd_1(ex_rd[1]), .ex_rd_2(ex_rd[2]),
      .stall(stall), .kill_1(kill_1), .kill_2(kill_2),
      .split_pending(split_pending), .stall_cnt(stall_cnt), .split_cnt(split_cnt)
   );

   dual_issue_scheduler #(.CNT_W(2), .REG_ADDR_W(RW)) dut_small (
      .clk(clk), .reset(rst), .flush(flush),
      .id_valid_1(valid[1]), .id_valid_2(valid[2]),
      .id_rs1_1(rs1[1]), .id_rs1_2(rs1[2]),
      .id_rs2_1(rs2[1]), .id_rs2_2(rs2[2]),
      .id_rd_1(rd[1]), .id_rd_2(rd[2]),
      .id_regwrite_1(regwrite[1]), .id_regwrite_2(regwrite[2]),
      .id_mem_1(mem[1]), .id_mem_2(mem[2]),
      .ex_memread_1(ex_mr[1]), .ex_memread_2(ex_mr[2]),
      .ex_rd_1(ex_rd[1]), .ex_rd_2(ex_rd[2]),
      .stall(s_stall), .kill_1(s_kill_1), .kill_2(s_kill_2),
      .split_pending(s_split_pending), .stall_cnt(s_stall_cnt), .split_cnt(s_split_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      flush = 1'b0;
      for (int s = 1; s <= 2; s++) begin
         valid[s] = 1'b0; rs1[s] = '0; rs2[s] = '0; rd[s] = '0;
         regwrite[s] = 1'b0; mem[s] = 1'b0; ex_mr[s] = 1'b0; ex_rd[s] = '0;
      end
   endtask

   task automatic set_slot(input int s, input logic [RW-1:0] a, input logic [RW-1:0] b,
                           input logic [RW-1:0] d, input logic wr, input logic m);
      valid[s] = 1'b1; rs1[s] = a; rs2[s] = b; rd[s] = d; regwrite[s] = wr; mem[s] = m;
   endtask

   task automatic set_ex(input int i, input logic m, input logic [RW-1:0] d);
      ex_mr[i] = m; ex_rd[i] = d;
   endtask

   // Slot s consumes a load currently in EX.
   function automatic bit load_use(input int s);
      bit hit = 0;
      for (int i = 1; i <= 2; i++)
         if (ex_mr[i] && ex_rd[i] != 0 && (ex_rd[i] == rs1[s] || ex_rd[i] == rs2[s]))
            hit = 1;
      return hit && valid[s];
   endfunction

   function automatic bit intra_pair();
      bit raw, structural, waw;
      raw        = regwrite[1] && rd[1] != 0 && (rd[1] == rs1[2] || rd[1] == rs2[2]);
      structural = mem[1] && mem[2];
      waw        = regwrite[1] && regwrite[2] && rd[1] == rd[2] && rd[1] != 0;
      return valid[1] && valid[2] && (raw || structural || waw);
   endfunction

   task automatic compute_expect();
      if (!rst) begin
         m_split = 0; m_stall_cnt = 0; m_split_cnt = 0; m_stall_cnt_small = 0;
      end
      {e_stall, e_kill_1, e_kill_2} = 3'b011;
      e_next_split = 0; e_stall_inc = 0; e_split_inc = 0;
      if (!rst || flush) begin
         e_next_split = 0;
      end else if (!m_split) begin
         if (load_use(1) || load_use(2)) begin
            e_stall = 1; e_stall_inc = 1;
         end else if (intra_pair()) begin
            e_stall = 1; e_kill_1 = 0; e_next_split = 1; e_split_inc = 1;
         end else begin
            e_kill_1 = !valid[1]; e_kill_2 = !valid[2];
         end
      end else begin
         if (load_use(2)) begin
            e_stall = 1; e_stall_inc = 1; e_next_split = 1;
         end else begin
            e_kill_2 = 0;
         end
      end
   endtask

   // One cycle: compare outputs mid-cycle, then advance the model across the rising edge.
   task automatic step(input string tag);
      #2;
      compute_expect();
      check({tag, ".stall"},    32'(stall),         32'(e_stall));
      check({tag, ".kill_1"},   32'(kill_1),        32'(e_kill_1));
      check({tag, ".kill_2"},   32'(kill_2),        32'(e_kill_2));
      check({tag, ".split"},    32'(split_pending), 32'(m_split));
      check({tag, ".stall_cnt"}, 32'(stall_cnt),    m_stall_cnt);
      check({tag, ".split_cnt"}, 32'(split_cnt),    m_split_cnt);
      check({tag, ".small_cnt"}, 32'(s_stall_cnt),  m_stall_cnt_small);
      @(posedge clk);
      if (rst) begin
         m_split = e_next_split;
         if (e_stall_inc) begin
            m_stall_cnt       = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : 65535;
            m_stall_cnt_small = (m_stall_cnt_small < 3) ? m_stall_cnt_small + 1 : 3;
         end
         if (e_split_inc)
            m_split_cnt = (m_split_cnt < 65535) ? m_split_cnt + 1 : 65535;
      end
      #1;
   endtask

   // Directed expectation written out by hand, checked ahead of the model comparison.
   task automatic expect_out(input string tag, input bit es, input bit ek1, input bit ek2);
      #1;
      check({tag, ".stall_d"},  32'(stall),  32'(es));
      check({tag, ".kill_1_d"}, 32'(kill_1), 32'(ek1));
      check({tag, ".kill_2_d"}, 32'(kill_2), 32'(ek2));
   endtask

   task automatic indep_pair();
      clear_inputs();
      set_slot(1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
      set_slot(2, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      #1;
      step("reset_hold");

      // Reset release, then go SPLIT and reset in the middle of it.
      rst = 1'b1;
      indep_pair();
      expect_out("rel_indep", 1'b0, 1'b0, 1'b0);
      step("rel_indep");
      clear_inputs();
      set_slot(1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      set_slot(2, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
      step("pre_rst_split");
      rst = 1'b0;
      #1;
      check("rst_mid.split_pending", 32'(split_pending), 32'd0);
      check("rst_mid.split_cnt",     32'(split_cnt),     32'd0);
      step("rst_mid");
      rst = 1'b1;
      indep_pair();
      expect_out("post_rst", 1'b0, 1'b0, 1'b0);
      step("post_rst");

      // Dependency: add x5 / sub x6,x5,x1.
      clear_inputs();
      set_slot(1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      set_slot(2, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
      expect_out("dep_c0", 1'b1, 1'b0, 1'b1);
      step("dep_c0");
      expect_out("dep_c1", 1'b0, 1'b1, 1'b0);
      step("dep_c1");
      indep_pair();
      step("dep_back_pair");
      check("dep.split_cnt", 32'(split_cnt), 32'd1);

      // Load-use on slot2's rs2.
      indep_pair();
      rs2[2] = 5'd7;
      set_ex(1, 1'b1, 5'd7);
      expect_out("lu", 1'b1, 1'b1, 1'b1);
      step("lu");
      set_ex(1, 1'b0, 5'd0);
      expect_out("lu_after", 1'b0, 1'b0, 1'b0);
      step("lu_after");

      // Split followed by slot2 consuming slot1's load.
      clear_inputs();
      set_slot(1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
      set_slot(2, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
      step("sl_c0");
      set_ex(1, 1'b1, 5'd3);
      expect_out("sl_c1", 1'b1, 1'b1, 1'b1);
      step("sl_c1");
      set_ex(1, 1'b0, 5'd0);
      expect_out("sl_c2", 1'b0, 1'b1, 1'b0);
      step("sl_c2");

      // Structural and WAW conflicts; x0 writes never conflict.
      clear_inputs();
      set_slot(1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      set_slot(2, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1);
      expect_out("two_st", 1'b1, 1'b0, 1'b1);
      step("two_st");
      step("two_st_s2");
      clear_inputs();
      set_slot(1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      set_slot(2, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
      step("waw9");
      step("waw9_s2");
      clear_inputs();
      set_slot(1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      set_slot(2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      expect_out("waw0", 1'b0, 1'b0, 1'b0);
      step("waw0");

      // Flush beats a simultaneous load-use and intra-pair conflict.
      clear_inputs();
      set_slot(1, 5'd7, 5'd2, 5'd5, 1'b1, 1'b1);
      set_slot(2, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
      set_ex(1, 1'b1, 5'd7);
      flush = 1'b1;
      expect_out("flush", 1'b0, 1'b1, 1'b1);
      step("flush");

      // Five load-use stalls saturate the 2-bit counter at 3.
      flush = 1'b0;
      for (int k = 0; k < 5; k++) step("sat");
      check("sat.small_cnt", 32'(s_stall_cnt), 32'd3);

      // Random traffic on a small register range to provoke hazards often.
      for (int k = 0; k < 400; k++) begin
         rst   = ($urandom_range(0, 99) != 0);
         flush = ($urandom_range(0, 9) == 0);
         for (int s = 1; s <= 2; s++) begin
            valid[s]    = ($urandom_range(0, 7) != 0);
            rs1[s]      = RW'($urandom_range(0, 6));
            rs2[s]      = RW'($urandom_range(0, 6));
            rd[s]       = RW'($urandom_range(0, 6));
            regwrite[s] = $urandom_range(0, 1) == 1;
            mem[s]      = ($urandom_range(0, 3) == 0);
            ex_mr[s]    = ($urandom_range(0, 3) == 0);
            ex_rd[s]    = RW'($urandom_range(0, 6));
         end
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
